// File: rtl/serial_tx.sv
// serial_tx: start/data/stop frame serializer, LSB first, idle high.
// Optional even parity bit after the data when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              Q,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              scnt, scnt_n;
  logic              q_r, q_n;
`ifdef SERIAL_TX_PARITY_EN
  logic              par, par_n;
`endif

  // state and datapath registers, synchronous reset to idle line
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      scnt  <= 1'b0;
      q_r   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      scnt  <= scnt_n;
      q_r   <= q_n;
`ifdef SERIAL_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  // next-state: everything holds unless en strobes (or a word is taken)
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    scnt_n  = scnt;
    q_n     = q_r;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        q_n = 1'b1;
        if (din_valid) begin
          state_n = START;
          sh_n    = din;
          q_n     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      START: begin
        if (en) begin
          state_n = DATA;
          q_n     = sh[0];
        end
      end
      DATA: begin
        if (en) begin
          if (cnt == CW'(DATA_W - 1)) begin
            cnt_n  = '0;
            scnt_n = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
            q_n     = par;
`else
            state_n = STOP;
            q_n     = 1'b1;
`endif
          end else begin
            cnt_n = cnt + CW'(1);
            sh_n  = sh >> 1;
            q_n   = sh[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (en) begin
          state_n = STOP;
          scnt_n  = 1'b0;
          q_n     = 1'b1;
        end
      end
`endif
      STOP: begin
        if (en) begin
          q_n = 1'b1;
          if (scnt == 1'(STOP_BITS - 1))
            state_n = IDLE;
          else
            scnt_n = scnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        q_n     = 1'b1;
      end
    endcase
  end

  assign din_ready = (state == IDLE);
  assign busy      = ~din_ready;
  assign Q         = q_r;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed plus random frames against a frame-list model.
// Model builds the expected bit list per word; checks Q per en period.
module tb_serial_tx;

  localparam int DW = 8;
  localparam int SB = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FLEN = 1 + DW + PB + SB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          Q;
  logic          busy;

  int nasrt = 0;
  int nfail = 0;

  serial_tx #(.DATA_W(DW), .STOP_BITS(SB)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .Q        (Q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nasrt++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_q"}, 32'(Q), 32'd1);
    chk({tag, "_rdy"}, 32'(din_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Send one word, en strobed every 'period' clocks; optional din noise.
  task automatic send(input logic [DW-1:0] w, input int period,
                      input bit noise);
    bit fr[$];
    int bcnt;
    bit p;
    fr.push_back(1'b0);
    p = 1'b0;
    for (int i = 0; i < DW; i++) begin
      fr.push_back(w[i]);
      p = p ^ w[i];
    end
    if (PB == 1) fr.push_back(p);
    for (int i = 0; i < SB; i++) fr.push_back(1'b1);
    chk("pre_rdy", 32'(din_ready), 32'd1);
    din = w;
    din_valid = 1'b1;
    en = (period == 1);
    cyc();
    din_valid = noise;
    din = DW'($urandom);
    chk("start_q", 32'(Q), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    bcnt = 1;
    for (int i = 1; i <= FLEN; i++) begin
      for (int k = 0; k < period - 1; k++) begin
        en = 1'b0;
        cyc();
        chk("hold_q", 32'(Q), 32'(fr[i-1]));
        bcnt += int'(busy);
        if (noise) din = DW'($urandom);
      end
      if (i == FLEN) din_valid = 1'b0;
      en = 1'b1;
      cyc();
      en = 1'b0;
      bcnt += int'(busy);
      if (noise) din = DW'($urandom);
      if (i < FLEN) begin
        chk("bit_q", 32'(Q), 32'(fr[i]));
        if (noise) chk("noise_rdy", 32'(din_ready), 32'd0);
      end else begin
        idle_chk("end");
      end
    end
    din_valid = 1'b0;
    chk("busy_len", 32'(bcnt), 32'(FLEN * period));
  endtask

  initial begin
    // reset with a word offered: nothing may be taken
    din = 8'hC3;
    din_valid = 1'b1;
    rst = 1'b1;
    cyc();
    idle_chk("rst1");
    cyc();
    idle_chk("rst2");
    rst = 1'b0;
    din_valid = 1'b0;
    cyc();
    idle_chk("post_rst");

    // en in idle is ignored
    en = 1'b1;
    cyc();
    cyc();
    idle_chk("idle_en");
    en = 1'b0;

    send(8'hA5, 1, 1'b0);
    send(8'h07, 2, 1'b0);
    send(8'h3C, 4, 1'b0);
    send(8'h55, 1, 1'b1);

    // abort in the middle of DATA
    din = 8'hFF;
    din_valid = 1'b1;
    en = 1'b1;
    cyc();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("abort_pre_q", 32'(Q), 32'd1);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle_chk("abort");
    cyc();
    cyc();
    idle_chk("abort_quiet");
    en = 1'b0;
    send(8'h81, 1, 1'b0);

    // random words, strobe spacing and collision noise
    for (int n = 0; n < 20; n++) begin
      send(DW'($urandom), int'($urandom_range(1, 4)),
           bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL provide parameter: DATA_W, default 8, payload bits per frame (legal 5..16).
REQ-002 SHALL provide parameter: STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-003 SHALL provide port: clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port: en  input  1  bit-time strobe, one-cycle pulse that advances the serial line by one bit.
REQ-006 SHALL provide port: din  input  DATA_W  parallel word to send.
REQ-007 SHALL provide port: din_valid  input  1  din holds a word.
REQ-008 SHALL provide port: din_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL provide port: Q  output  1  registered serial line, idle high.
REQ-010 SHALL provide port: busy  output  1  a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-012 SHALL assert din_ready only in IDLE; busy SHALL equal NOT din_ready.
REQ-013 SHALL accept a word on the rising edge where din_valid=1 and din_ready=1, regardless of en; din SHALL be latched into an internal shift register at that edge and SHALL be don't-care afterwards.
REQ-014 SHALL, on acceptance, enter START with Q=0 after the same edge (latency 1 clk from accept to start bit).
REQ-015 SHALL hold state, shift register, bit counter and Q unchanged on any cycle with en=0 (except acceptance in IDLE).
REQ-016 START + en=1: go to DATA, Q=bit 0 (LSB first).
REQ-017 DATA + en=1: if bit counter < DATA_W-1, shift and drive next bit; else go to PARITY (macro on) or STOP (macro off) with Q=parity or Q=1 respectively.
REQ-018 STOP + en=1: if STOP_BITS stop periods have elapsed, go to IDLE with Q=1; else remain in STOP with Q=1.
REQ-019 SHALL ignore en in IDLE; Q SHALL stay 1.
REQ-020 SHALL ignore din_valid while busy; the in-flight frame SHALL be unaffected.
REQ-021 SHALL give every bit exactly one en-period (from the en pulse that starts it to the next en pulse); frame length = 1 + DATA_W + parity + STOP_BITS en pulses.
REQ-022 SHALL guarantee at least one IDLE cycle (din_ready=1) between consecutive frames.
REQ-023 SHALL count bits with a counter of width ceil(log2(DATA_W)) that wraps to 0 at each DATA exit.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, force IDLE, Q=1, din_ready=1, busy=0, counter=0, shift register=0.
REQ-025 SHALL give rst priority over en and din_valid; reset mid-frame SHALL abort the frame with no further bits and Q=1 on the next cycle.
REQ-026 SHALL not accept a word on a cycle where rst=1.

Configuration
REQ-027 SHALL compile the parity stage only when macro SERIAL_TX_PARITY_EN is defined.
REQ-028 With SERIAL_TX_PARITY_EN: one PARITY bit after DATA equal to XOR of all DATA_W data bits (even parity), held one en-period.
REQ-029 Without SERIAL_TX_PARITY_EN: no PARITY state or logic; DATA goes directly to STOP.

Verification
REQ-030 Reset: rst=1 for 2 cycles, din_valid=1 -> Q=1, din_ready=1, busy=0, nothing accepted.
REQ-031 Frame: DATA_W=8, macro off, en=1 every cycle, din=0xA5 accepted -> Q from next cycle = 0,1,0,1,0,0,1,0,1,1 then IDLE; busy high for exactly 10 cycles.
REQ-032 Parity: macro on, din=0xA5 -> parity bit 0; din=0x07 -> parity bit 1; both placed after bit 7 and before the stop bit.
REQ-033 Strobe spacing: en one cycle in four, din=0x3C -> each bit held exactly 4 clk; Q unchanged while en=0.
REQ-034 Abort: rst=1 during DATA bit 3 of 0xFF -> Q=1 next cycle, din_ready=1; new word 0x81 then sends a full, correct frame.
REQ-035 Busy collision: change din and pulse din_valid during DATA of 0x55 -> transmitted bits match 0x55; second word accepted only after return to IDLE.
